// File: rtl/regwr_pkg.sv
// Shared defaults and helpers for the register-file write-port arbiter.
package regwr_pkg;

    localparam int NREQ_DEF   = 4;
    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 32;
    localparam int PTR_W_DEF  = $clog2(NREQ_DEF);

    // Base bit offset of requester idx inside a packed per-requester bus.
    function automatic int unsigned slice_base(input int unsigned idx, input int unsigned w);
        return idx * w;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: rotate requests by ptr, take the lowest
// set bit, then rotate the winner back to its absolute index.
module rr_pick #(
    parameter int NREQ  = 4,
    parameter int PTR_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  grant,
    output logic [PTR_W-1:0] idx
);

    localparam logic [PTR_W:0] NREQ_W = (PTR_W+1)'(NREQ);

    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    logic [PTR_W-1:0]  off;
    logic [PTR_W:0]    sum;
    logic              found;

    always_comb begin
        dbl   = {req, req} >> ptr;
        rot   = dbl[NREQ-1:0];
        found = 1'b0;
        off   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                off   = PTR_W'(i);
            end
        end
        // Undo the rotation modulo NREQ (NREQ need not be a power of two).
        sum = {1'b0, off} + {1'b0, ptr};
        if (sum >= NREQ_W) sum = sum - NREQ_W;
        idx   = sum[PTR_W-1:0];
        grant = '0;
        if (found) grant[idx] = 1'b1;
    end

endmodule

// File: rtl/regwr_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NREQ
// requesters, with stall gating and optional address-0 write discard.
module regwr_arbiter
    import regwr_pkg::*;
#(
    parameter int NREQ         = NREQ_DEF,
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int ZERO_DISCARD = 1
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    output logic [NREQ-1:0]          req_ready,
    input  logic                     stall,
    output logic                     WE,
    output logic [ADDR_W-1:0]        Addr,
    output logic [DATA_W-1:0]        Data,
    output logic [$clog2(NREQ)-1:0]  last_grant
);

    localparam int PTR_W = $clog2(NREQ);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NREQ - 1);

    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  next_ptr;
    logic [NREQ-1:0]   grant;
    logic [PTR_W-1:0]  pick_idx;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic              hs;
    logic              discard;

    rr_pick #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant),
        .idx   (pick_idx)
    );

    // Grant is one-hot of a valid requester, so any ready bit is a handshake.
    always_comb begin
        req_ready = stall ? '0 : grant;
        hs        = |req_ready;
        sel_addr  = req_addr[slice_base(32'(pick_idx), ADDR_W) +: ADDR_W];
        sel_data  = req_data[slice_base(32'(pick_idx), DATA_W) +: DATA_W];
        next_ptr  = (pick_idx == LAST_IDX) ? '0 : pick_idx + 1'b1;
        discard   = (ZERO_DISCARD != 0) && (sel_addr == '0);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ptr        <= '0;
            WE         <= 1'b0;
            Addr       <= '0;
            Data       <= '0;
            last_grant <= '0;
        end else begin
            WE <= 1'b0;
            if (hs) begin
                ptr        <= next_ptr;
                last_grant <= pick_idx;
                Addr       <= sel_addr;
                Data       <= sel_data;
                WE         <= !discard;
            end
        end
    end

endmodule

// File: tb/tb_regwr_arbiter.sv
// Directed self-checking bench for regwr_arbiter (NREQ=4, ADDR_W=5, DATA_W=32).
module tb_regwr_arbiter;

    localparam int NREQ   = 4;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    logic                   CLK = 1'b0;
    logic                   RST = 1'b0;
    logic [NREQ-1:0]        req_valid = '0;
    logic [NREQ*ADDR_W-1:0] req_addr = '0;
    logic [NREQ*DATA_W-1:0] req_data = '0;
    logic [NREQ-1:0]        req_ready;
    logic                   stall = 1'b0;
    logic                   WE;
    logic [ADDR_W-1:0]      Addr;
    logic [DATA_W-1:0]      Data;
    logic [1:0]             last_grant;

    int errors = 0;
    int checks = 0;

    regwr_arbiter #(
        .NREQ         (NREQ),
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .ZERO_DISCARD (1)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .stall      (stall),
        .WE         (WE),
        .Addr       (Addr),
        .Data       (Data),
        .last_grant (last_grant)
    );

    always #5 CLK = ~CLK;

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        req_addr[i*ADDR_W +: ADDR_W] = a;
        req_data[i*DATA_W +: DATA_W] = d;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        req_valid = '0;
        stall = 1'b0;
        RST = 1'b1;
        step();
        checks++;
        if ({WE, Addr, Data, last_grant} !== '0) begin
            errors++;
            $display("FAIL reset_regs: WE=%0b Addr=%0d Data=%h last=%0d required all 0", WE, Addr, Data, last_grant);
        end
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ready: got %b required 0000", req_ready);
        end
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_single();
        step();
        set_req(2, 5'd3, 32'hA5);
        req_valid = 4'b0100;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL single_ready: got %b required 0100", req_ready);
        end
        step();
        req_valid = '0;
        checks++;
        if (WE !== 1'b1 || Addr !== 5'd3 || Data !== 32'hA5 || last_grant !== 2'd2) begin
            errors++;
            $display("FAIL single_write: WE=%0b Addr=%0d Data=%h last=%0d required 1/3/a5/2", WE, Addr, Data, last_grant);
        end
        step();
        checks++;
        if (WE !== 1'b0) begin
            errors++;
            $display("FAIL single_we_drop: got %0b required 0", WE);
        end
    endtask

    // Entered with ptr=3 (last grant was requester 2).
    task automatic test_wrap();
        set_req(3, 5'd30, 32'h33);
        set_req(0, 5'd10, 32'h11);
        req_valid = 4'b1001;
        #1;
        checks++;
        if (req_ready !== 4'b1000) begin
            errors++;
            $display("FAIL wrap_first: got %b required 1000", req_ready);
        end
        step();
        req_valid = 4'b0001;
        #1;
        checks++;
        if (req_ready !== 4'b0001 || last_grant !== 2'd3 || Addr !== 5'd30) begin
            errors++;
            $display("FAIL wrap_second: ready=%b last=%0d Addr=%0d required 0001/3/30", req_ready, last_grant, Addr);
        end
        step();
        req_valid = '0;
        checks++;
        if (WE !== 1'b1 || last_grant !== 2'd0 || Data !== 32'h11) begin
            errors++;
            $display("FAIL wrap_write0: WE=%0b last=%0d Data=%h required 1/0/11", WE, last_grant, Data);
        end
    endtask

    task automatic test_round_robin();
        test_reset();
        step();
        for (int i = 0; i < NREQ; i++) set_req(i, 5'(i + 1), 32'h100 + 32'(i));
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1;
            checks++;
            if (req_ready !== 4'(1 << (k % 4))) begin
                errors++;
                $display("FAIL rr_ready[%0d]: got %b required %b", k, req_ready, 4'(1 << (k % 4)));
            end
            step();
            checks++;
            if (WE !== 1'b1 || Addr !== 5'((k % 4) + 1) || Data !== 32'h100 + 32'(k % 4) || last_grant !== 2'(k % 4)) begin
                errors++;
                $display("FAIL rr_write[%0d]: WE=%0b Addr=%0d Data=%h last=%0d required 1/%0d/%h/%0d",
                         k, WE, Addr, Data, last_grant, (k % 4) + 1, 32'h100 + 32'(k % 4), k % 4);
            end
        end
        req_valid = '0;
        step();
        checks++;
        if (WE !== 1'b0) begin
            errors++;
            $display("FAIL rr_we_end: got %0b required 0", WE);
        end
    endtask

    // Entered with ptr=0.
    task automatic test_stall();
        set_req(0, 5'd4, 32'hAA);
        set_req(1, 5'd5, 32'hBB);
        req_valid = 4'b0011;
        step();
        stall = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0000 || WE !== 1'b1 || last_grant !== 2'd0) begin
            errors++;
            $display("FAIL stall_rise: ready=%b WE=%0b last=%0d required 0000/1/0", req_ready, WE, last_grant);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (req_ready !== 4'b0000 || WE !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold[%0d]: ready=%b WE=%0b required 0000/0", k, req_ready, WE);
            end
        end
        stall = 1'b0;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL stall_resume: got %b required 0010", req_ready);
        end
        step();
        req_valid = '0;
        checks++;
        if (WE !== 1'b1 || last_grant !== 2'd1 || Addr !== 5'd5) begin
            errors++;
            $display("FAIL stall_resume_write: WE=%0b last=%0d Addr=%0d required 1/1/5", WE, last_grant, Addr);
        end
    endtask

    task automatic test_zero_discard();
        test_reset();
        step();
        set_req(1, 5'd0, 32'h77);
        req_valid = 4'b0010;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL zero_ready: got %b required 0010", req_ready);
        end
        step();
        req_valid = '0;
        checks++;
        if (WE !== 1'b0 || last_grant !== 2'd1) begin
            errors++;
            $display("FAIL zero_discard: WE=%0b last=%0d required 0/1", WE, last_grant);
        end
        set_req(0, 5'd1, 32'h1);
        set_req(2, 5'd2, 32'h2);
        req_valid = 4'b0111;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL zero_ptr_adv: got %b required 0100", req_ready);
        end
        req_valid = '0;
    endtask

    // Entered with ptr=2.
    task automatic test_reset_midop();
        step();
        set_req(2, 5'd9, 32'hDEAD);
        req_valid = 4'b0100;
        step();
        req_valid = '0;
        RST = 1'b1;
        #1;
        checks++;
        if (WE !== 1'b0 || Addr !== 5'd0 || Data !== 32'h0 || last_grant !== 2'd0) begin
            errors++;
            $display("FAIL midreset_clear: WE=%0b Addr=%0d Data=%h last=%0d required all 0", WE, Addr, Data, last_grant);
        end
        step();
        @(negedge CLK);
        RST = 1'b0;
        set_req(1, 5'd6, 32'hC6);
        set_req(3, 5'd7, 32'hC7);
        req_valid = 4'b1010;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL midreset_restart: got %b required 0010", req_ready);
        end
        step();
        req_valid = '0;
        checks++;
        if (WE !== 1'b1 || last_grant !== 2'd1 || Data !== 32'hC6) begin
            errors++;
            $display("FAIL midreset_write: WE=%0b last=%0d Data=%h required 1/1/c6", WE, last_grant, Data);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_round_robin();
        test_stall();
        test_zero_discard();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regwr_arbiter.md
# regwr_arbiter

Round-robin arbiter sharing the single write port of the datapath register file among up to NREQ requesters (ALU writeback, load unit, etc.). Each requester presents address and data under a valid/ready handshake; the arbiter grants one per cycle and drives a registered WE/Addr/Data write strobe to the register file. A datapath stall input freezes all grants. Writes to address 0 are accepted but discarded when ZERO_DISCARD is set.

## Interface
- NREQ, 4, number of requesters (2..8)
- ADDR_W, 5, register address width
- DATA_W, 32, register data width
- ZERO_DISCARD, 1, 1 = accepted writes to address 0 produce no WE pulse
- CLK  in  1  rising-edge clock
- RST  in  1  reset, asynchronous, active-high
- req_valid  in  NREQ  requester i has a pending write
- req_addr  in  NREQ*ADDR_W  requester i address in slice [i*ADDR_W +: ADDR_W]
- req_data  in  NREQ*DATA_W  requester i data in slice [i*DATA_W +: DATA_W]
- req_ready  out  NREQ  one-hot grant, combinational; handshake = valid & ready at CLK edge
- stall  in  1  datapath hold; forces req_ready = 0
- WE  out  1  register-file write enable, registered
- Addr  out  ADDR_W  register-file write address, registered
- Data  out  DATA_W  register-file write data, registered
- last_grant  out  clog2(NREQ)  index of most recent accepted requester, registered

## Operation
- Priority pointer ptr (clog2(NREQ) bits). Search order: ptr, ptr+1, ..., wrapping mod NREQ; first valid requester wins.
- req_ready = one-hot of winner when stall = 0 and any req_valid; else all zeros. Never more than one bit set.
- On handshake with requester i: ptr <= (i+1) mod NREQ (wrap at NREQ-1 -> 0), last_grant <= i, Addr <= req_addr[i], Data <= req_data[i], WE <= 1 unless ZERO_DISCARD and address = 0.
- No handshake: WE <= 0; Addr, Data, last_grant, ptr hold.
- Fairness: continuously valid requester waits at most NREQ-1 grants.
- Requesters must hold valid/addr/data stable until handshake; arbiter does not buffer.
- req_valid dropping without handshake is legal; no state change.
- Address-0 discard still completes handshake and advances ptr.

## Timing
- Reset: WE=0, Addr=0, Data=0, last_grant=0, ptr=0; req_ready follows combinational rule (all 0 while no valid).
- Latency: handshake at edge t -> WE high for exactly one cycle after edge t, register file captures at edge t+1.
- Throughput: one write per cycle; back-to-back grants yield continuous WE.
- stall rising: req_ready drops same cycle; WE from a handshake at the previous edge still issues (not cancelled).
- stall held: WE = 0 from the second cycle on; ptr frozen.
- RST asserted mid-operation: all registers clear immediately; in-flight WE dropped; a requester with no completed handshake retries after release. First grant after reset starts search at requester 0.

## Structure
- Package regwr_pkg: NREQ/ADDR_W/DATA_W defaults, PTR_W = clog2(NREQ) constant, function for slice extraction.
- Sub-module rr_pick (combinational): inputs req vector and ptr, outputs one-hot grant and encoded index; rotate-priority-unrotate implementation.
- Top: pointer register, output registers, stall gating, zero-address filter.

## Test plan
- Reset then single request: req_valid=0b0100, addr=3, data=0xA5 -> req_ready=0b0100 same cycle; next cycle WE=1, Addr=3, Data=0xA5, last_grant=2; following cycle WE=0.
- All four valid for 8 cycles, addr=i+1 -> grant order 0,1,2,3,0,1,2,3; WE high 8 consecutive cycles.
- Wrap: ptr=3 after grant to 2, req_valid=0b1001 -> grant 3, then 0.
- stall=1 for 3 cycles with 0b0011 valid -> req_ready=0, WE=0 after first cycle, ptr unchanged; on release grant resumes at saved ptr.
- ZERO_DISCARD=1, requester 1 writes addr=0 -> handshake completes, WE stays 0, ptr advances to 2, last_grant=1.
- RST pulsed one cycle after a handshake -> WE, Addr, Data cleared, WE pulse absent; post-reset grant starts at requester 0.
